gates_bist_ctrl: RTL and testbench
==================================

# gates_bist_ctrl

Built-in self-test sequencer for the `gates` logic-function unit (y[0..6] = OR, AND, NOR, NAND, XOR, XNOR, NOT).
- On a start request it drives the unit's two inputs through all four combinations, waits a programmable settle time for each, and captures the 8-bit result.
- It compares each capture against an internal reference model and reports pass/fail, a per-function fail mask, a per-vector fail mask and the raw capture log.
- It sits between the test/config logic and one `gates` instance.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles inputs are held before capture; 0 is legal.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE, no done.
- gate_a  out  1  registered input a to gates.
- gate_b  out  1  registered input b to gates.
- gate_y  in  8  gates result; bit 7 ignored.
- busy  out  1  high from accept edge until final capture edge.
- done  out  1  one-cycle pulse after final capture.
- pass  out  1  1 when fail_mask==0; valid from done, held until next accept.
- fail_mask  out  7  bit f set if function f mismatched on any vector.
- fail_vec  out  4  bit k set if vector k had any mismatch.
- cap_log  out  28  captured gate_y[6:0] of vector k at [7k+6:7k].

## Operation
- Vector order k=0..3: {a,b} = 00, 01, 10, 11, so a=k[1] and b=k[0].
- Expected values: OR=a|b, AND=a&b, NOR=~(a|b), NAND=~(a&b), XOR=a^b, XNOR=~(a^b), NOT=~a.
- States and transitions:
  - IDLE: wait for start. On start, go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
  - SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
  - CAPTURE: one cycle. At its end edge, sample gate_y, update cap_log, fail_mask and fail_vec, then:
    - if k<3, apply vector k+1 and return to SETTLE/CAPTURE;
    - if k=3, go to IDLE, pulse done and clear busy.
- Accept edge:
  - clears fail_mask, fail_vec and cap_log;
  - sets busy=1, k=0, gate_a=0, gate_b=0;
  - sets pass=0.
- fail_mask and fail_vec accumulate by OR across the run.
- pass is computed at the final capture edge.
- start while busy is ignored.
- start and abort on the same edge in IDLE: abort wins, nothing is accepted.
- abort while busy:
  - next edge goes to IDLE with busy=0, done=0, gate_a=gate_b=0;
  - pass=0; cap_log and fail masks keep their partial contents.
- Reset values (asynchronous on rst_n low, including mid-run): every output is 0, state is IDLE, k is 0.
- Settle counter width is max(1, $clog2(SETTLE_CYCLES+1)).

## Timing
- Edge E0 is the accept edge.
- Vector k is applied at edge E0 + k·(SETTLE_CYCLES+1).
- Vector k is sampled at edge E0 + (k+1)·(SETTLE_CYCLES+1); the same edge applies vector k+1.
- busy: high in the cycle after E0; low after edge E0 + 4·(SETTLE_CYCLES+1).
- done: high for exactly the cycle after that edge.
- Total run is 4·(SETTLE_CYCLES+1) cycles; with the default (2) that is 12 cycles.
- A new start is accepted in the cycle done is high (state is already IDLE).
- Outputs are registered; there are no combinational paths from gate_y to outputs.

## Structure
- gates_pkg holds:
  - function index constants F_OR=0 … F_NOT=6 and NUM_FUNCS=7;
  - the state enum (IDLE, SETTLE, CAPTURE);
  - NUM_VECS=4.
- gates_expect is the one sub-module: combinational reference model, a and b in, 7-bit expected value out, using the same bit mapping. The controller instantiates it once, fed by gate_a/gate_b.
- The bench instantiates the real `gates` block connected to gate_a/gate_b/gate_y, plus a fault-injecting wrapper.

## Test plan
- Golden `gates` with SETTLE_CYCLES=2, start pulsed once:
  - done at E0+12;
  - pass=1, fail_mask=0, fail_vec=0;
  - cap_log fields k0..k3 = 0x6C, 0x59, 0x19, 0x23.
- y[1] (AND) stuck-at-0 -> pass=0, fail_mask=7'h02, fail_vec=4'b1000, cap_log k3 field=0x21.
- y[7] toggling randomly, golden otherwise -> pass=1, and cap_log is unchanged from the golden run.
- SETTLE_CYCLES=0 -> gate_a/gate_b step 00,01,10,11 on consecutive edges, done at E0+4, busy high for 4 cycles.
- Disturbance cases:
  - start re-pulsed while busy -> no restart, done at the original time;
  - abort during vector 2 -> busy=0 next cycle, done never pulses, pass=0;
  - rst_n low during vector 1 -> all outputs 0 immediately.
- Back-to-back: start asserted in the done cycle -> new run accepted, fail masks cleared, second done 12 cycles later.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared constants for the gates logic-function unit and its BIST sequencer.
//   F_* : bit index of each function in the gates result vector
//   state_e : sequencer states
package gates_pkg;

  localparam int unsigned F_OR      = 0;
  localparam int unsigned F_AND     = 1;
  localparam int unsigned F_NOR     = 2;
  localparam int unsigned F_NAND    = 3;
  localparam int unsigned F_XOR     = 4;
  localparam int unsigned F_XNOR    = 5;
  localparam int unsigned F_NOT     = 6;
  localparam int unsigned NUM_FUNCS = 7;
  localparam int unsigned NUM_VECS  = 4;
  localparam int unsigned VEC_W     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/gates.sv
// Logic-function unit under test: y[6:0] = OR, AND, NOR, NAND, XOR, XNOR, NOT(a).
//   a_i, b_i : operands
//   y_o      : results; bit 7 is spare and driven low
module gates
  import gates_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o         = '0;
    y_o[F_OR]   = a_i | b_i;
    y_o[F_AND]  = a_i & b_i;
    y_o[F_NOR]  = ~(a_i | b_i);
    y_o[F_NAND] = ~(a_i & b_i);
    y_o[F_XOR]  = a_i ^ b_i;
    y_o[F_XNOR] = ~(a_i ^ b_i);
    y_o[F_NOT]  = ~a_i;
  end

endmodule

// File: rtl/gates_expect.sv
// Reference model of the gates unit used by the BIST comparator.
//   a_i, b_i : applied operands
//   exp_o    : expected y[6:0], same bit mapping as gates
module gates_expect
  import gates_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_FUNCS-1:0] exp_o
);

  always_comb begin
    exp_o         = '0;
    exp_o[F_OR]   = a_i | b_i;
    exp_o[F_AND]  = a_i & b_i;
    exp_o[F_NOR]  = ~(a_i | b_i);
    exp_o[F_NAND] = ~(a_i & b_i);
    exp_o[F_XOR]  = a_i ^ b_i;
    exp_o[F_XNOR] = ~(a_i ^ b_i);
    exp_o[F_NOT]  = ~a_i;
  end

endmodule

// File: rtl/gates_bist_ctrl.sv
// BIST sequencer for one gates instance: walks {a,b} through 00,01,10,11,
// settles, captures y[6:0], compares against gates_expect and reports.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : run request (IDLE only), synchronous cancel
//   gate_a, gate_b    : registered operands to gates
//   gate_y            : gates result (bit 7 ignored)
//   busy, done, pass  : run status
//   fail_mask/fail_vec: per-function / per-vector mismatch flags
//   cap_log           : captured y[6:0] of vector k at [7k+6:7k]
module gates_bist_ctrl
  import gates_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            gate_a,
  output logic                            gate_b,
  input  logic [7:0]                      gate_y,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [NUM_FUNCS-1:0]            fail_mask,
  output logic [NUM_VECS-1:0]             fail_vec,
  output logic [NUM_VECS*NUM_FUNCS-1:0]   cap_log
);

  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned CNT_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [VEC_W-1:0] K_LAST = VEC_W'(NUM_VECS - 1);

  state_e                          state_q, state_d;
  logic [VEC_W-1:0]                k_q, k_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            gate_a_q, gate_a_d, gate_b_q, gate_b_d;
  logic                            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [NUM_FUNCS-1:0]            fail_mask_q, fail_mask_d;
  logic [NUM_VECS-1:0]             fail_vec_q, fail_vec_d;
  logic [NUM_VECS*NUM_FUNCS-1:0]   cap_log_q, cap_log_d;
  logic [NUM_FUNCS-1:0]            exp_c, mism_c;
  logic                            gate_y_unused;

  assign gate_y_unused = gate_y[7];

  gates_expect u_expect (
    .a_i   (gate_a_q),
    .b_i   (gate_b_q),
    .exp_o (exp_c)
  );

  assign mism_c = gate_y[NUM_FUNCS-1:0] ^ exp_c;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      fail_vec_q  <= '0;
      cap_log_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      fail_vec_q  <= fail_vec_d;
      cap_log_q   <= cap_log_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    fail_vec_d  = fail_vec_q;
    cap_log_d   = cap_log_q;

    unique case (state_q)
      IDLE: begin
        // abort on the same edge suppresses the accept
        if (start && !abort) begin
          state_d     = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
          k_d         = '0;
          cnt_d       = '0;
          gate_a_d    = 1'b0;
          gate_b_d    = 1'b0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          fail_mask_d = '0;
          fail_vec_d  = '0;
          cap_log_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(CNT_LAST)) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        for (int unsigned k = 0; k < NUM_VECS; k++) begin
          if (k_q == VEC_W'(k)) begin
            cap_log_d[k*NUM_FUNCS +: NUM_FUNCS] = gate_y[NUM_FUNCS-1:0];
          end
        end
        fail_mask_d      = fail_mask_q | mism_c;
        fail_vec_d[k_q]  = fail_vec_q[k_q] | (|mism_c);
        if (k_q == K_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == '0);
        end else begin
          // vector k+1 goes out on the same edge that samples vector k
          k_d      = k_q + VEC_W'(1);
          gate_a_d = k_d[1];
          gate_b_d = k_d[0];
          state_d  = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // cancel a run in progress; partial logs and masks are kept
    if (state_q != IDLE && abort) begin
      state_d  = IDLE;
      k_d      = '0;
      cnt_d    = '0;
      gate_a_d = 1'b0;
      gate_b_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign fail_vec  = fail_vec_q;
  assign cap_log   = cap_log_q;

endmodule

// File: tb/tb_gates_bist_ctrl.sv
// Directed bench for gates_bist_ctrl: default-settle DUT with fault injection
// on its gates result, plus a zero-settle DUT on a clean gates instance.
module tb_gates_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic        start0 = 1'b0, abort0 = 1'b0;
  logic        fault_and = 1'b0, y7_en = 1'b0, y7_rnd = 1'b0;

  logic        gate_a, gate_b, busy, done, pass;
  logic [7:0]  gate_y, gold_y;
  logic [6:0]  fail_mask;
  logic [3:0]  fail_vec;
  logic [27:0] cap_log;

  logic        gate_a0, gate_b0, busy0, done0, pass0;
  logic [7:0]  gate_y0;
  logic [6:0]  fail_mask0;
  logic [3:0]  fail_vec0;
  logic [27:0] cap_log0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [27:0] GOLD_LOG = {7'h23, 7'h19, 7'h59, 7'h6C};
  localparam logic [27:0] AND_LOG  = {7'h21, 7'h19, 7'h59, 7'h6C};
  localparam logic [27:0] PART_LOG = {7'h00, 7'h00, 7'h59, 7'h6C};

  always #5 clk = ~clk;

  always @(negedge clk) y7_rnd <= 1'($urandom_range(0, 1));

  gates u_gates (.a_i(gate_a), .b_i(gate_b), .y_o(gold_y));

  // fault injection between gates and the controller
  assign gate_y = {y7_en ? y7_rnd : gold_y[7], gold_y[6:2],
                   fault_and ? 1'b0 : gold_y[1], gold_y[0]};

  gates_bist_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .fail_vec(fail_vec), .cap_log(cap_log)
  );

  gates u_gates0 (.a_i(gate_a0), .b_i(gate_b0), .y_o(gate_y0));

  gates_bist_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gate_a(gate_a0), .gate_b(gate_b0), .gate_y(gate_y0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fail_mask0), .fail_vec(fail_vec0), .cap_log(cap_log0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Assert start across one edge (E0); returns #1 after E0.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after E0 until done; start is re-driven at step 'repulse'.
  task automatic wait_done(input int repulse, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      start = (i == repulse);
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    int done_seen;

    // reset
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", {gate_a, gate_b, busy, done, pass}, 0);
    check_eq("rst_masks", {fail_mask, fail_vec}, 0);
    check_eq("rst_log", cap_log, 0);
    check_eq("rst_outs0", {gate_a0, gate_b0, busy0, done0, pass0}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // golden run, default settle
    pulse_start();
    check_eq("gold_busy_e0", busy, 1);
    check_eq("gold_ab_e0", {gate_a, gate_b}, 0);
    wait_done(0, n);
    check_eq("gold_done_lat", n, 12);
    check_eq("gold_pass", pass, 1);
    check_eq("gold_fmask", fail_mask, 0);
    check_eq("gold_fvec", fail_vec, 0);
    check_eq("gold_log", cap_log, GOLD_LOG);
    check_eq("gold_busy_end", busy, 0);
    @(posedge clk); #1;
    check_eq("gold_done_1cyc", done, 0);
    check_eq("gold_pass_hold", pass, 1);

    // AND output stuck at 0
    fault_and = 1'b1;
    pulse_start();
    wait_done(0, n);
    check_eq("and_done_lat", n, 12);
    check_eq("and_pass", pass, 0);
    check_eq("and_fmask", fail_mask, 7'h02);
    check_eq("and_fvec", fail_vec, 4'b1000);
    check_eq("and_log", cap_log, AND_LOG);
    fault_and = 1'b0;

    // spare bit 7 toggling must not matter
    y7_en = 1'b1;
    pulse_start();
    wait_done(0, n);
    check_eq("y7_done_lat", n, 12);
    check_eq("y7_pass", pass, 1);
    check_eq("y7_log", cap_log, GOLD_LOG);
    y7_en = 1'b0;

    // zero settle: one vector per edge
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    check_eq("z_ab_0", {gate_a0, gate_b0}, 0);
    check_eq("z_busy_0", busy0, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check_eq("z_ab_step", {gate_a0, gate_b0}, i);
      check_eq("z_busy_step", {busy0, done0}, 2'b10);
    end
    @(posedge clk); #1;
    check_eq("z_done", done0, 1);
    check_eq("z_busy_end", busy0, 0);
    check_eq("z_pass", pass0, 1);
    check_eq("z_log", cap_log0, GOLD_LOG);

    // start re-pulsed mid-run is ignored
    pulse_start();
    wait_done(4, n);
    check_eq("repulse_done_lat", n, 12);
    @(posedge clk); #1;
    check_eq("repulse_no_restart", {busy, done}, 0);

    // start and abort together in IDLE: nothing accepted
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    check_eq("idle_abort_wins", busy, 0);

    // abort during vector 2
    pulse_start();
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_ab", {gate_a, gate_b}, 0);
    check_eq("abort_pass", pass, 0);
    check_eq("abort_log", cap_log, PART_LOG);
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);

    // async reset during vector 1
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_mid_b_pre", {gate_a, gate_b, busy}, 3'b011);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outs", {gate_a, gate_b, busy, done, pass}, 0);
    check_eq("rst_mid_log", {fail_mask, fail_vec, cap_log}, 0);
    @(negedge clk) rst_n = 1'b1;

    // back-to-back: failing run, then restart in its done cycle
    fault_and = 1'b1;
    pulse_start();
    wait_done(0, n);
    check_eq("b2b_first_fmask", fail_mask, 7'h02);
    start = 1'b1;
    fault_and = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("b2b_accept_busy", busy, 1);
    check_eq("b2b_cleared", {fail_mask, fail_vec, cap_log}, 0);
    check_eq("b2b_pass_clr", pass, 0);
    wait_done(0, n);
    check_eq("b2b_done_lat", n, 12);
    check_eq("b2b_pass", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
